// File: rtl/seg7_pkg.sv
// Shared glyph constants, scan FSM states and the glyph-to-nibble decode for the
// seven-segment scan decoder. Segment order is {a,b,c,d,e,f,g}, active-low.
package seg7_pkg;

   localparam logic [6:0] SEG_0    = 7'b0000001;
   localparam logic [6:0] SEG_1    = 7'b1001111;
   localparam logic [6:0] SEG_2    = 7'b0010010;
   localparam logic [6:0] SEG_3    = 7'b0000110;
   localparam logic [6:0] SEG_4    = 7'b1001100;
   localparam logic [6:0] SEG_5    = 7'b0100100;
   localparam logic [6:0] SEG_6    = 7'b0100000;
   localparam logic [6:0] SEG_7    = 7'b0001111;
   localparam logic [6:0] SEG_8    = 7'b0000000;
   localparam logic [6:0] SEG_9    = 7'b0000100;
   localparam logic [6:0] SEG_A    = 7'b0001000;
   localparam logic [6:0] SEG_C    = 7'b0110001;
   localparam logic [6:0] SEG_D    = 7'b1000010;
   localparam logic [6:0] SEG_E    = 7'b0110000;
   localparam logic [6:0] SEG_F    = 7'b0111000;
   localparam logic [6:0] SEG_DASH = 7'b1111110;

   typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

   typedef struct packed {
      logic       known;
      logic       dash;
      logic [3:0] nibble;
   } glyph_t;

   // "B" lights the same segments as "8", so that glyph always reads back as 8.
   function automatic glyph_t glyph_decode(input logic [6:0] seg);
      glyph_t g;
      g.known  = 1'b1;
      g.dash   = 1'b0;
      g.nibble = 4'h0;
      case (seg)
         SEG_0:    g.nibble = 4'h0;
         SEG_1:    g.nibble = 4'h1;
         SEG_2:    g.nibble = 4'h2;
         SEG_3:    g.nibble = 4'h3;
         SEG_4:    g.nibble = 4'h4;
         SEG_5:    g.nibble = 4'h5;
         SEG_6:    g.nibble = 4'h6;
         SEG_7:    g.nibble = 4'h7;
         SEG_8:    g.nibble = 4'h8;
         SEG_9:    g.nibble = 4'h9;
         SEG_A:    g.nibble = 4'hA;
         SEG_C:    g.nibble = 4'hC;
         SEG_D:    g.nibble = 4'hD;
         SEG_E:    g.nibble = 4'hE;
         SEG_F:    g.nibble = 4'hF;
         SEG_DASH: begin
            g.known = 1'b0;
            g.dash  = 1'b1;
         end
         default:  g.known = 1'b0;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational cathode-pattern classifier: hex glyph, dash, or unknown.
module seg7_glyph_decode
   import seg7_pkg::*;
(
   input  logic [6:0] i_cathode,
   output logic       o_known,
   output logic       o_dash,
   output logic [3:0] o_nibble
);

   glyph_t w_glyph;

   always_comb begin
      w_glyph  = glyph_decode(i_cathode);
      o_known  = w_glyph.known;
      o_dash   = w_glyph.dash;
      o_nibble = w_glyph.nibble;
   end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Rebuilds the four hex digits shown on a multiplexed 7-segment scan bus and
// publishes each completed frame with a one-cycle strobe, plus E404 and timeout flags.
module seg7_scan_decoder
   import seg7_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES  = 16,
   parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  anode,
   input  logic [6:0]  cathode,
   output logic [15:0] digits,
   output logic [3:0]  digit_known,
   output logic [3:0]  dash_mask,
   output logic        frame_valid,
   output logic        err_pattern,
   output logic        timeout
);

   localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
   localparam int unsigned FW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [SW-1:0] STAB_ONE  = SW'(1);
   localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
   localparam logic [FW-1:0] TMO_MAX   = FW'(TIMEOUT_CYCLES);
   localparam logic [FW-1:0] TMO_LAST  = FW'(TIMEOUT_CYCLES - 1);

   logic [3:0]    r_an_p0, r_an_p1, r_an_p2;
   logic [6:0]    r_ca_p0, r_ca_p1, r_ca_p2;
   state_t        r_state;
   logic [SW-1:0] r_stab_cnt;
   logic [FW-1:0] r_frame_cnt;
   logic [3:0]    r_seen;
   logic [15:0]   r_sh_digits;
   logic [3:0]    r_sh_known;
   logic [3:0]    r_sh_dash;
   logic [15:0]   r_digits;
   logic [3:0]    r_known;
   logic [3:0]    r_dash;
   logic          r_frame_valid;
   logic          r_err;
   logic          r_timeout;

   logic          w_sel_valid;
   logic [1:0]    w_sel_idx;
   logic          w_same;
   logic          w_capture;
   logic          w_complete;
   logic [3:0]    w_cap_bit;
   logic          w_known;
   logic          w_dash;
   logic [3:0]    w_nibble;

   // Stage p0/p1: two-flop synchroniser; p2 holds the previous synchronised sample.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_an_p0 <= '0;
         r_an_p1 <= '0;
         r_an_p2 <= '0;
         r_ca_p0 <= '0;
         r_ca_p1 <= '0;
         r_ca_p2 <= '0;
      end else begin
         r_an_p0 <= anode;
         r_an_p1 <= r_an_p0;
         r_an_p2 <= r_an_p1;
         r_ca_p0 <= cathode;
         r_ca_p1 <= r_ca_p0;
         r_ca_p2 <= r_ca_p1;
      end
   end

   always_comb begin
      w_sel_valid = 1'b1;
      w_sel_idx   = 2'd0;
      case (r_an_p1)
         4'b1110: w_sel_idx = 2'd0;
         4'b1101: w_sel_idx = 2'd1;
         4'b1011: w_sel_idx = 2'd2;
         4'b0111: w_sel_idx = 2'd3;
         default: w_sel_valid = 1'b0;
      endcase
   end

   seg7_glyph_decode u_glyph (
      .i_cathode (r_ca_p1),
      .o_known   (w_known),
      .o_dash    (w_dash),
      .o_nibble  (w_nibble)
   );

   assign w_same     = (r_an_p1 == r_an_p2) && (r_ca_p1 == r_ca_p2);
   assign w_capture  = (r_state == SETTLE) && w_sel_valid && w_same && (r_stab_cnt == STAB_LAST);
   assign w_complete = (r_seen == 4'b1111);
   assign w_cap_bit  = w_capture ? (4'b0001 << w_sel_idx) : 4'b0000;

   // Stability FSM: a digit is captured once per unbroken hold of STABLE_CYCLES samples.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_stab_cnt <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_sel_valid) begin
                  r_state    <= SETTLE;
                  r_stab_cnt <= STAB_ONE;
               end
            end
            SETTLE: begin
               if (!w_sel_valid) begin
                  r_state    <= IDLE;
                  r_stab_cnt <= '0;
               end else if (!w_same) begin
                  r_stab_cnt <= STAB_ONE;
               end else if (r_stab_cnt == STAB_LAST) begin
                  r_state    <= HELD;
                  r_stab_cnt <= r_stab_cnt + STAB_ONE;
               end else begin
                  r_stab_cnt <= r_stab_cnt + STAB_ONE;
               end
            end
            HELD: begin
               if (!w_sel_valid) begin
                  r_state    <= IDLE;
                  r_stab_cnt <= '0;
               end else if (!w_same) begin
                  r_state    <= SETTLE;
                  r_stab_cnt <= STAB_ONE;
               end
            end
            default: begin
               r_state    <= IDLE;
               r_stab_cnt <= '0;
            end
         endcase
      end
   end

   // Frame assembly: shadow slots fill independently, outputs copy them in one shot.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_sh_digits   <= '0;
         r_sh_known    <= '0;
         r_sh_dash     <= '0;
         r_seen        <= '0;
         r_frame_cnt   <= '0;
         r_digits      <= '0;
         r_known       <= '0;
         r_dash        <= '0;
         r_frame_valid <= 1'b0;
         r_err         <= 1'b0;
         r_timeout     <= 1'b0;
      end else begin
         r_frame_valid <= 1'b0;
         if (w_capture) begin
            r_sh_digits[{w_sel_idx, 2'b00} +: 4] <= w_nibble;
            r_sh_known[w_sel_idx]                <= w_known;
            r_sh_dash[w_sel_idx]                 <= w_dash;
         end
         if (w_complete) begin
            r_digits      <= r_sh_digits;
            r_known       <= r_sh_known;
            r_dash        <= r_sh_dash;
            r_err         <= (r_sh_digits == 16'hE404) && (r_sh_known == 4'hF);
            r_frame_valid <= 1'b1;
            r_seen        <= w_cap_bit;
            r_frame_cnt   <= '0;
            r_timeout     <= 1'b0;
         end else begin
            if (r_frame_cnt != TMO_MAX) begin
               r_frame_cnt <= r_frame_cnt + FW'(1);
            end
            // Partial frames are dropped only once, as the counter first reaches the limit.
            if (r_frame_cnt == TMO_LAST) begin
               r_timeout <= 1'b1;
               r_seen    <= w_cap_bit;
            end else begin
               r_seen    <= r_seen | w_cap_bit;
            end
         end
      end
   end

   assign digits      = r_digits;
   assign digit_known = r_known;
   assign dash_mask   = r_dash;
   assign frame_valid = r_frame_valid;
   assign err_pattern = r_err;
   assign timeout     = r_timeout;

endmodule
